// File: rtl/usb_rcv_pkt.sv
// Bit-serial USB receive packet decoder: PID check, token CRC5, handshakes,
// and DATA0/DATA1 streaming into the 1-bit receive FIFO with CRC16 checking.
module usb_rcv_pkt #(
    parameter int MAX_BITS = 8240
) (
    input  logic        clk,
    input  logic        rst0_async,
    input  logic        rst0_sync,
    input  logic        rx_bit,
    input  logic        rx_bit_valid,
    input  logic        rx_eop,
    input  logic        rx_err,
    input  logic        fifo_full,
    output logic        wr_en,
    output logic        wr_data,
    output logic        wr_minus16,
    output logic [3:0]  pid,
    output logic        tok_valid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic        hsk_valid,
    output logic        data_ok,
    output logic        data_err,
    output logic [10:0] data_len
);

    localparam int CNT_W = $clog2(MAX_BITS + 2);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSK, S_WAIT_EOP
    } state_t;

    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b);
        logic fb;
        fb = crc[4] ^ b;
        return {crc[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    state_t           state_r;
    logic [7:0]       pid_sr_r;
    logic [10:0]      tok_sr_r;
    logic [4:0]       crc5_r;
    logic [15:0]      crc16_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic             wr_minus16_r;
    logic [3:0]       pid_r;
    logic             tok_valid_r;
    logic [6:0]       tok_addr_r;
    logic [3:0]       tok_endp_r;
    logic             hsk_valid_r;
    logic             data_ok_r;
    logic             data_err_r;
    logic [10:0]      data_len_r;

    logic       bit_s;
    logic [7:0] pid_byte_s;
    logic       tok_good_s;
    logic       data_good_s;

    // An EOP or line error in the same cycle always drops the bit.
    assign bit_s       = rx_bit_valid && !rx_eop && !rx_err;
    assign pid_byte_s  = {rx_bit, pid_sr_r[7:1]};
    assign tok_good_s  = (cnt_r == CNT_W'(16)) && (crc5_r == 5'b01100);
    assign data_good_s = (crc16_r == 16'h800D) && (cnt_r[2:0] == 3'd0) &&
                         (cnt_r >= CNT_W'(16)) && (cnt_r <= MAX_CNT) && !ovf_r;

    assign wr_en   = rst0_sync && (state_r == S_DATA) && bit_s && !fifo_full && (cnt_r < MAX_CNT);
    assign wr_data = wr_en & rx_bit;

    assign wr_minus16 = wr_minus16_r;
    assign pid        = pid_r;
    assign tok_valid  = tok_valid_r;
    assign tok_addr   = tok_addr_r;
    assign tok_endp   = tok_endp_r;
    assign hsk_valid  = hsk_valid_r;
    assign data_ok    = data_ok_r;
    assign data_err   = data_err_r;
    assign data_len   = data_len_r;

    // Packet FSM with all registered results.
    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async) begin
            state_r      <= S_IDLE;
            pid_sr_r     <= 8'h00;
            tok_sr_r     <= 11'h000;
            crc5_r       <= 5'h00;
            crc16_r      <= 16'h0000;
            cnt_r        <= '0;
            ovf_r        <= 1'b0;
            wr_minus16_r <= 1'b0;
            pid_r        <= 4'h0;
            tok_valid_r  <= 1'b0;
            tok_addr_r   <= 7'h00;
            tok_endp_r   <= 4'h0;
            hsk_valid_r  <= 1'b0;
            data_ok_r    <= 1'b0;
            data_err_r   <= 1'b0;
            data_len_r   <= 11'h000;
        end else if (!rst0_sync) begin
            state_r      <= S_IDLE;
            pid_sr_r     <= 8'h00;
            tok_sr_r     <= 11'h000;
            crc5_r       <= 5'h00;
            crc16_r      <= 16'h0000;
            cnt_r        <= '0;
            ovf_r        <= 1'b0;
            wr_minus16_r <= 1'b0;
            pid_r        <= 4'h0;
            tok_valid_r  <= 1'b0;
            tok_addr_r   <= 7'h00;
            tok_endp_r   <= 4'h0;
            hsk_valid_r  <= 1'b0;
            data_ok_r    <= 1'b0;
            data_err_r   <= 1'b0;
            data_len_r   <= 11'h000;
        end else begin
            wr_minus16_r <= 1'b0;
            tok_valid_r  <= 1'b0;
            hsk_valid_r  <= 1'b0;
            data_ok_r    <= 1'b0;
            data_err_r   <= 1'b0;
            // A line error inside a packet is reported once; WAIT_EOP already reported.
            if (rx_err && (state_r != S_IDLE) && (state_r != S_WAIT_EOP)) begin
                data_err_r <= 1'b1;
                state_r    <= rx_eop ? S_IDLE : S_WAIT_EOP;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (bit_s) begin
                            pid_sr_r <= {rx_bit, 7'h00};
                            cnt_r    <= CNT_W'(1);
                            crc5_r   <= 5'h1F;
                            crc16_r  <= 16'hFFFF;
                            ovf_r    <= 1'b0;
                            state_r  <= S_PID;
                        end
                    end
                    S_PID: begin
                        if (rx_eop) begin
                            data_err_r <= 1'b1;
                            state_r    <= S_IDLE;
                        end else if (rx_bit_valid) begin
                            pid_sr_r <= pid_byte_s;
                            if (cnt_r == CNT_W'(7)) begin
                                cnt_r <= '0;
                                if (pid_byte_s[7:4] == ~pid_byte_s[3:0]) begin
                                    pid_r <= pid_byte_s[3:0];
                                    // PID[1:0] selects the packet class.
                                    case (pid_byte_s[1:0])
                                        2'b01: state_r <= S_TOKEN;
                                        2'b10: state_r <= S_HSK;
                                        2'b11: begin
                                            if (pid_byte_s[2] == 1'b0) begin
                                                state_r <= S_DATA;
                                            end else begin
                                                data_err_r <= 1'b1;
                                                state_r    <= S_WAIT_EOP;
                                            end
                                        end
                                        default: begin
                                            data_err_r <= 1'b1;
                                            state_r    <= S_WAIT_EOP;
                                        end
                                    endcase
                                end else begin
                                    data_err_r <= 1'b1;
                                    state_r    <= S_WAIT_EOP;
                                end
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    S_TOKEN: begin
                        if (rx_eop) begin
                            state_r <= S_IDLE;
                            if (tok_good_s) begin
                                tok_valid_r <= 1'b1;
                                tok_addr_r  <= tok_sr_r[6:0];
                                tok_endp_r  <= tok_sr_r[10:7];
                            end else begin
                                data_err_r <= 1'b1;
                            end
                        end else if (rx_bit_valid) begin
                            if (cnt_r == CNT_W'(16)) begin
                                data_err_r <= 1'b1;
                                state_r    <= S_WAIT_EOP;
                            end else begin
                                if (cnt_r < CNT_W'(11)) begin
                                    tok_sr_r <= {rx_bit, tok_sr_r[10:1]};
                                end
                                crc5_r <= crc5_step(crc5_r, rx_bit);
                                cnt_r  <= cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    S_HSK: begin
                        if (rx_eop) begin
                            hsk_valid_r <= 1'b1;
                            state_r     <= S_IDLE;
                        end else if (rx_bit_valid) begin
                            data_err_r <= 1'b1;
                            state_r    <= S_WAIT_EOP;
                        end
                    end
                    S_DATA: begin
                        if (rx_eop) begin
                            state_r <= S_IDLE;
                            // The trailing CRC bits are always rewound once they are in the FIFO.
                            wr_minus16_r <= (cnt_r >= CNT_W'(16));
                            if (data_good_s) begin
                                data_ok_r  <= 1'b1;
                                data_len_r <= 11'((cnt_r - CNT_W'(16)) >> 3);
                            end else begin
                                data_err_r <= 1'b1;
                            end
                        end else if (rx_bit_valid) begin
                            if (cnt_r == MAX_CNT) begin
                                data_err_r <= 1'b1;
                                state_r    <= S_WAIT_EOP;
                            end else begin
                                crc16_r <= crc16_step(crc16_r, rx_bit);
                                cnt_r   <= cnt_r + CNT_W'(1);
                                if (fifo_full) begin
                                    ovf_r <= 1'b1;
                                end
                            end
                        end
                    end
                    S_WAIT_EOP: begin
                        if (rx_eop) begin
                            state_r <= S_IDLE;
                        end
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rcv_pkt.sv
// Scoreboard bench for usb_rcv_pkt: expected FIFO bits are queued as data is
// driven and checked as writes appear; result pulses are checked per scenario.
module tb_usb_rcv_pkt;

    logic        clk;
    logic        rst0_async;
    logic        rst0_sync;
    logic        rx_bit;
    logic        rx_bit_valid;
    logic        rx_eop;
    logic        rx_err;
    logic        fifo_full;
    logic        wr_en;
    logic        wr_data;
    logic        wr_minus16;
    logic [3:0]  pid;
    logic        tok_valid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        hsk_valid;
    logic        data_ok;
    logic        data_err;
    logic [10:0] data_len;

    usb_rcv_pkt dut (
        .clk(clk), .rst0_async(rst0_async), .rst0_sync(rst0_sync),
        .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid), .rx_eop(rx_eop),
        .rx_err(rx_err), .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
        .wr_minus16(wr_minus16), .pid(pid), .tok_valid(tok_valid),
        .tok_addr(tok_addr), .tok_endp(tok_endp), .hsk_valid(hsk_valid),
        .data_ok(data_ok), .data_err(data_err), .data_len(data_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic exp_q[$];
    logic fifo_q[$];
    logic exp_bit;
    int n_wr, n_m16, n_ok, n_err, n_tok, n_hsk;
    logic [7:0] pay [0:7];

    // Monitor: checks every FIFO write against the scoreboard and models the FIFO.
    always @(negedge clk) begin
        if (wr_en) begin
            n_wr++;
            fifo_q.push_back(wr_data);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got write of %0b, wanted no write", wr_data);
            end else begin
                exp_bit = exp_q.pop_front();
                if (wr_data !== exp_bit) begin
                    bad++;
                    $display("FAIL wr_data: got %0b want %0b", wr_data, exp_bit);
                end
            end
        end
        if (wr_minus16) begin
            n_m16++;
            for (int i = 0; i < 16; i++) begin
                if (fifo_q.size() > 0) fifo_q.pop_back();
            end
        end
        n_ok  += int'(data_ok);
        n_err += int'(data_err);
        n_tok += int'(tok_valid);
        n_hsk += int'(hsk_valid);
    end

    function automatic logic [4:0] crc5_usb(input logic [10:0] v);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (c[0] ^ v[i]) c = (c >> 1) ^ 5'h14;
            else             c = c >> 1;
        end
        return c ^ 5'h1F;
    endfunction

    function automatic logic [15:0] crc16_usb(input int nb);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < nb; k++) begin
            c = c ^ {8'h00, pay[k]};
            for (int i = 0; i < 8; i++) begin
                if (c[0]) c = (c >> 1) ^ 16'hA001;
                else      c = c >> 1;
            end
        end
        return ~c;
    endfunction

    function automatic logic [7:0] fifo_byte(input int k);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = fifo_q[8*k + i];
        return r;
    endfunction

    task automatic cyc(input logic v, input logic b, input logic e, input logic er);
        rx_bit_valid = v; rx_bit = b; rx_eop = e; rx_err = er;
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b, input bit push);
        if (push && !fifo_full) exp_q.push_back(b);
        cyc(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit push);
        for (int i = 0; i < 8; i++) send_bit(d[i], push);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_eop();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_token(input logic [7:0] p, input logic [6:0] a, input logic [3:0] e, input bit flip);
        logic [15:0] w;
        w = {crc5_usb({e, a}), e, a};
        if (flip) w[12] = ~w[12];
        send_byte(p, 1'b0);
        for (int i = 0; i < 16; i++) send_bit(w[i], 1'b0);
        send_eop();
    endtask

    task automatic send_data(input logic [7:0] p, input int nb, input int flip_bit, input int full_byte);
        logic [15:0] c;
        logic [7:0] d;
        c = crc16_usb(nb);
        send_byte(p, 1'b0);
        for (int k = 0; k < nb; k++) begin
            d = pay[k];
            if (flip_bit >= 0 && flip_bit / 8 == k) d[flip_bit % 8] = ~d[flip_bit % 8];
            fifo_full = (k == full_byte);
            send_byte(d, 1'b1);
        end
        fifo_full = 1'b0;
        send_byte(c[7:0], 1'b1);
        send_byte(c[15:8], 1'b1);
        send_eop();
    endtask

    task automatic clr_counts();
        n_wr = 0; n_m16 = 0; n_ok = 0; n_err = 0; n_tok = 0; n_hsk = 0;
        fifo_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst0_async = 1'b1;
        idle();
        total++; if (pid !== 4'h0) begin bad++; $display("FAIL rst_pid: got %0h want 0", pid); end
        total++; if (data_len !== 11'd0) begin bad++; $display("FAIL rst_len: got %0d want 0", data_len); end
        total++; if ({wr_en, wr_minus16, tok_valid, hsk_valid, data_ok, data_err} !== 6'b0)
            begin bad++; $display("FAIL rst_pulses: got %b want 000000", {wr_en, wr_minus16, tok_valid, hsk_valid, data_ok, data_err}); end
        total++; if ({tok_addr, tok_endp} !== 11'd0) begin bad++; $display("FAIL rst_tok: got %0h want 0", {tok_addr, tok_endp}); end
    endtask

    task automatic test_token();
        clr_counts();
        send_token(8'h2D, 7'h05, 4'h0, 1'b0);
        total++; if (tok_valid !== 1'b1) begin bad++; $display("FAIL tok_valid: got %0b want 1", tok_valid); end
        total++; if (tok_addr !== 7'h05) begin bad++; $display("FAIL tok_addr: got %0h want 05", tok_addr); end
        total++; if (tok_endp !== 4'h0) begin bad++; $display("FAIL tok_endp: got %0h want 0", tok_endp); end
        total++; if (pid !== 4'hD) begin bad++; $display("FAIL tok_pid: got %0h want d", pid); end
        idle();
        total++; if (tok_valid !== 1'b0) begin bad++; $display("FAIL tok_pulse_width: got %0b want 0", tok_valid); end
        send_token(8'h2D, 7'h33, 4'h7, 1'b1);
        total++; if ({tok_valid, data_err} !== 2'b01) begin bad++; $display("FAIL tok_badcrc: got tok/err=%b want 01", {tok_valid, data_err}); end
        total++; if (tok_addr !== 7'h05) begin bad++; $display("FAIL tok_addr_held: got %0h want 05", tok_addr); end
        idle();
    endtask

    task automatic test_data_good();
        clr_counts();
        send_data(8'hC3, 8, -1, -1);
        total++; if ({wr_minus16, data_ok, data_err} !== 3'b110) begin bad++; $display("FAIL data_result: got m16/ok/err=%b want 110", {wr_minus16, data_ok, data_err}); end
        total++; if (data_len !== 11'd8) begin bad++; $display("FAIL data_len: got %0d want 8", data_len); end
        idle();
        total++; if ({wr_minus16, data_ok} !== 2'b00) begin bad++; $display("FAIL data_pulse_width: got %b want 00", {wr_minus16, data_ok}); end
        total++; if (n_wr !== 80 || n_m16 !== 1) begin bad++; $display("FAIL data_counts: got wr=%0d m16=%0d want 80 1", n_wr, n_m16); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL data_missing: got %0d unwritten bits want 0", exp_q.size()); end
        if (fifo_q.size() == 64) begin
            total++; if (fifo_byte(0) !== 8'h80 || fifo_byte(1) !== 8'h06)
                begin bad++; $display("FAIL fifo_req: got %0h %0h want 80 06", fifo_byte(0), fifo_byte(1)); end
            total++; if ({fifo_byte(3), fifo_byte(2)} !== 16'h0100)
                begin bad++; $display("FAIL fifo_wvalue: got %0h want 0100", {fifo_byte(3), fifo_byte(2)}); end
        end else begin
            total++; bad++;
            $display("FAIL fifo_size: got %0d want 64", fifo_q.size());
        end
    endtask

    task automatic test_data_bad_crc();
        clr_counts();
        send_data(8'hC3, 8, 21, -1);
        total++; if ({wr_minus16, data_ok, data_err} !== 3'b101) begin bad++; $display("FAIL badcrc_result: got m16/ok/err=%b want 101", {wr_minus16, data_ok, data_err}); end
        total++; if (data_len !== 11'd8) begin bad++; $display("FAIL badcrc_len: got %0d want 8", data_len); end
        idle();
    endtask

    task automatic test_bad_pid();
        clr_counts();
        send_byte(8'hC2, 1'b0);
        total++; if (data_err !== 1'b1) begin bad++; $display("FAIL badpid_err: got %0b want 1", data_err); end
        for (int i = 0; i < 10; i++) send_bit(1'(i % 2), 1'b0);
        send_eop();
        total++; if ({data_err, hsk_valid, data_ok} !== 3'b000) begin bad++; $display("FAIL badpid_eop: got %b want 000", {data_err, hsk_valid, data_ok}); end
        send_byte(8'hD2, 1'b0);
        send_eop();
        total++; if (hsk_valid !== 1'b1 || pid !== 4'h2) begin bad++; $display("FAIL ack: got hsk=%0b pid=%0h want 1 2", hsk_valid, pid); end
        idle();
        total++; if (n_wr !== 0 || n_err !== 1 || n_hsk !== 1) begin bad++; $display("FAIL badpid_counts: got wr=%0d err=%0d hsk=%0d want 0 1 1", n_wr, n_err, n_hsk); end
    endtask

    task automatic test_lengths();
        clr_counts();
        send_byte(8'h4B, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(1'(i % 3 == 0), 1'b1);
        send_eop();
        total++; if ({wr_minus16, data_ok, data_err} !== 3'b101) begin bad++; $display("FAIL len20: got m16/ok/err=%b want 101", {wr_minus16, data_ok, data_err}); end
        idle();
        send_byte(8'hC3, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_eop();
        total++; if ({wr_minus16, data_ok, data_err} !== 3'b001) begin bad++; $display("FAIL len8: got m16/ok/err=%b want 001", {wr_minus16, data_ok, data_err}); end
        idle();
        clr_counts();
        send_data(8'hC3, 8, -1, 3);
        total++; if ({wr_minus16, data_ok, data_err} !== 3'b101) begin bad++; $display("FAIL full_result: got m16/ok/err=%b want 101", {wr_minus16, data_ok, data_err}); end
        idle();
        total++; if (n_wr !== 72 || exp_q.size() !== 0) begin bad++; $display("FAIL full_writes: got wr=%0d left=%0d want 72 0", n_wr, exp_q.size()); end
        total++; if (data_len !== 11'd8) begin bad++; $display("FAIL full_len: got %0d want 8", data_len); end
    endtask

    task automatic test_line_err();
        clr_counts();
        send_byte(8'hC3, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'(i % 2), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (data_err !== 1'b1) begin bad++; $display("FAIL rxerr: got %0b want 1", data_err); end
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        send_eop();
        total++; if ({wr_minus16, data_err, data_ok} !== 3'b000) begin bad++; $display("FAIL rxerr_eop: got %b want 000", {wr_minus16, data_err, data_ok}); end
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        send_eop();
        total++; if (data_err !== 1'b1) begin bad++; $display("FAIL short_pid: got %0b want 1", data_err); end
        idle();
        total++; if (n_err !== 2 || n_wr !== 10) begin bad++; $display("FAIL lineerr_counts: got err=%0d wr=%0d want 2 10", n_err, n_wr); end
    endtask

    task automatic test_back_to_back();
        clr_counts();
        send_byte(8'hD2, 1'b0);
        send_eop();
        total++; if (hsk_valid !== 1'b1) begin bad++; $display("FAIL b2b_hsk: got %0b want 1", hsk_valid); end
        send_token(8'h69, 7'h7F, 4'hF, 1'b0);
        total++; if (tok_valid !== 1'b1 || tok_addr !== 7'h7F || tok_endp !== 4'hF || pid !== 4'h9)
            begin bad++; $display("FAIL b2b_tok: got v=%0b a=%0h e=%0h pid=%0h want 1 7f f 9", tok_valid, tok_addr, tok_endp, pid); end
        idle();
        total++; if (n_hsk !== 1 || n_tok !== 1 || n_err !== 0) begin bad++; $display("FAIL b2b_counts: got hsk=%0d tok=%0d err=%0d want 1 1 0", n_hsk, n_tok, n_err); end
    endtask

    task automatic test_async_reset();
        clr_counts();
        send_byte(8'hC3, 1'b0);
        send_byte(pay[0], 1'b1);
        send_byte(pay[1], 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        rx_bit_valid = 1'b1; rx_bit = 1'b1;
        #1;
        rst0_async = 1'b0;
        #1;
        total++; if ({wr_en, wr_data} !== 2'b00) begin bad++; $display("FAIL arst_wr: got %b want 00", {wr_en, wr_data}); end
        total++; if (pid !== 4'h0 || data_len !== 11'd0 || tok_addr !== 7'h00)
            begin bad++; $display("FAIL arst_regs: got pid=%0h len=%0d addr=%0h want 0 0 0", pid, data_len, tok_addr); end
        rx_bit_valid = 1'b0;
        @(posedge clk); #3;
        rst0_async = 1'b1;
        @(posedge clk); #1;
        send_token(8'hE1, 7'h12, 4'h3, 1'b0);
        total++; if (tok_valid !== 1'b1 || tok_addr !== 7'h12 || tok_endp !== 4'h3 || pid !== 4'h1)
            begin bad++; $display("FAIL arst_tok: got v=%0b a=%0h e=%0h pid=%0h want 1 12 3 1", tok_valid, tok_addr, tok_endp, pid); end
        idle();
        total++; if (exp_q.size() !== 0 || n_err !== 0 || n_m16 !== 0) begin bad++; $display("FAIL arst_counts: got left=%0d err=%0d m16=%0d want 0 0 0", exp_q.size(), n_err, n_m16); end
        rst0_sync = 1'b0;
        idle();
        rst0_sync = 1'b1;
        total++; if (tok_addr !== 7'h00 || pid !== 4'h0) begin bad++; $display("FAIL srst: got addr=%0h pid=%0h want 0 0", tok_addr, pid); end
    endtask

    initial begin
        rst0_async = 1'b0; rst0_sync = 1'b1;
        rx_bit = 1'b0; rx_bit_valid = 1'b0; rx_eop = 1'b0; rx_err = 1'b0; fifo_full = 1'b0;
        pay[0] = 8'h80; pay[1] = 8'h06; pay[2] = 8'h00; pay[3] = 8'h01;
        pay[4] = 8'h00; pay[5] = 8'h00; pay[6] = 8'h40; pay[7] = 8'h00;
        clr_counts();
        test_reset();
        test_token();
        test_data_good();
        test_data_bad_crc();
        test_bad_pid();
        test_lengths();
        test_line_err();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
